// File: rtl/mem_req_pkg.sv
// Shared definitions for the memory request front-end: controller state
// encoding, default completion timeout, bus widths and the alignment rule.
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ERR  = 2'b10
  } state_e;

  localparam int DEFAULT_TIMEOUT = 64;
  localparam int ALIGN_BIT       = 0;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;

  // A request is illegal when it asks for both load and store, or when the
  // address is not halfword aligned.
  function automatic logic is_illegal(input logic rd, input logic wr,
                                      input logic [ADDR_W-1:0] addr);
    return (rd & wr) | addr[ALIGN_BIT];
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Bus bundles around mem_req_ctrl.
//   mem_req_pipe_if  : pipeline memory stage <-> controller
//     req_rd/req_wr/req_addr/req_wdata (pipeline -> ctrl),
//     rd_data/done/pipe_stall/err      (ctrl -> pipeline)
//     master = pipeline, slave = controller
//   mem_req_cache_if : controller <-> cache
//     c_addr/c_data_in/c_rd/c_wr             (ctrl -> cache)
//     c_data_out/c_done/c_stall/c_hit/c_err  (cache -> ctrl)
//     master = controller, slave = cache
interface mem_req_pipe_if;
  import mem_req_pkg::*;
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              pipe_stall;
  logic              err;

  modport master (output req_rd, req_wr, req_addr, req_wdata,
                  input  rd_data, done, pipe_stall, err);
  modport slave  (input  req_rd, req_wr, req_addr, req_wdata,
                  output rd_data, done, pipe_stall, err);
endinterface

interface mem_req_cache_if;
  import mem_req_pkg::*;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data_in;
  logic              c_rd;
  logic              c_wr;
  logic [DATA_W-1:0] c_data_out;
  logic              c_done;
  logic              c_stall;
  logic              c_hit;
  logic              c_err;

  modport master (output c_addr, c_data_in, c_rd, c_wr,
                  input  c_data_out, c_done, c_stall, c_hit, c_err);
  modport slave  (input  c_addr, c_data_in, c_rd, c_wr,
                  output c_data_out, c_done, c_stall, c_hit, c_err);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared only by rst.
//   clk, rst (sync, active-high), inc (count enable), count (W-bit value)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register with saturation at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mem_req_ctrl.sv
// Request front-end between the pipeline memory stage and the cache.
// Accepts one load/store at a time, rejects misaligned or rd&wr requests,
// holds the cache request stable across a multi-cycle miss, stalls the
// pipeline meanwhile, aborts with err after TIMEOUT_CYCLES busy cycles,
// and keeps saturating hit/miss completion counters.
//   clk, rst       : clock, synchronous active-high reset
//   pipe (slave)   : pipeline request / result bus
//   cache (master) : cache request / response bus (c_stall is not used)
//   hit_cnt        : saturating count of hit completions
//   miss_cnt       : saturating count of miss completions
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_pipe_if.slave    pipe,
  mem_req_cache_if.master  cache,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int               TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_r, state_nxt_s;
  logic [TMO_W-1:0]  tmo_cnt_r, tmo_nxt_s;
  logic [ADDR_W-1:0] hold_addr_r;
  logic [DATA_W-1:0] hold_wdata_r, last_rdata_r;
  logic              hold_rd_r, hold_wr_r;

  logic              valid_s, illegal_s, capture_s, rd_done_s;
  logic              hit_inc_s, miss_inc_s;
  logic [ADDR_W-1:0] c_addr_s;
  logic [DATA_W-1:0] c_data_in_s;
  logic              c_rd_s, c_wr_s, done_s, err_s, stall_s;

  assign valid_s   = pipe.req_rd | pipe.req_wr;
  assign illegal_s = is_illegal(pipe.req_rd, pipe.req_wr, pipe.req_addr);

  // Next-state and raw output decode for the request FSM.
  always_comb begin
    state_nxt_s = state_r;
    tmo_nxt_s   = tmo_cnt_r;
    c_addr_s    = pipe.req_addr;
    c_data_in_s = pipe.req_wdata;
    c_rd_s      = 1'b0;
    c_wr_s      = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    stall_s     = 1'b0;
    capture_s   = 1'b0;
    rd_done_s   = 1'b0;
    hit_inc_s   = 1'b0;
    miss_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_s && illegal_s) begin
          // Rejected on the spot: never reaches the cache.
          done_s = 1'b1;
          err_s  = 1'b1;
        end else if (valid_s) begin
          c_rd_s    = pipe.req_rd;
          c_wr_s    = pipe.req_wr;
          capture_s = 1'b1;
          if (cache.c_err) begin
            done_s = 1'b1;
            err_s  = 1'b1;
          end else if (cache.c_done) begin
            done_s     = 1'b1;
            rd_done_s  = pipe.req_rd;
            hit_inc_s  = cache.c_hit;
            miss_inc_s = ~cache.c_hit;
          end else begin
            stall_s     = 1'b1;
            state_nxt_s = BUSY;
            tmo_nxt_s   = '0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        c_addr_s    = hold_addr_r;
        c_data_in_s = hold_wdata_r;
        c_rd_s      = hold_rd_r;
        c_wr_s      = hold_wr_r;
        if (cache.c_err) begin
          // Keep the pipeline frozen until the ERR cycle reports the abort.
          stall_s     = 1'b1;
          state_nxt_s = ERR;
          tmo_nxt_s   = '0;
        end else if (cache.c_done) begin
          done_s      = 1'b1;
          rd_done_s   = hold_rd_r;
          miss_inc_s  = 1'b1;
          state_nxt_s = IDLE;
          tmo_nxt_s   = '0;
        end else if (tmo_cnt_r == TMO_LAST) begin
          stall_s     = 1'b1;
          state_nxt_s = ERR;
          tmo_nxt_s   = '0;
        end else begin
          stall_s   = 1'b1;
          tmo_nxt_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      ERR: begin
        c_addr_s    = hold_addr_r;
        c_data_in_s = hold_wdata_r;
        done_s      = 1'b1;
        err_s       = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        tmo_nxt_s   = '0;
      end
    endcase
  end

  // State, timeout, hold and last-read registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      tmo_cnt_r    <= '0;
      hold_addr_r  <= '0;
      hold_wdata_r <= '0;
      hold_rd_r    <= 1'b0;
      hold_wr_r    <= 1'b0;
      last_rdata_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_nxt_s;
      if (rd_done_s) begin
        last_rdata_r <= cache.c_data_out;
      end else begin
        last_rdata_r <= last_rdata_r;
      end
      if (capture_s) begin
        hold_addr_r  <= pipe.req_addr;
        hold_wdata_r <= pipe.req_wdata;
        hold_rd_r    <= pipe.req_rd;
        hold_wr_r    <= pipe.req_wr;
      end else if (state_r == ERR) begin
        hold_addr_r  <= '0;
        hold_wdata_r <= '0;
        hold_rd_r    <= 1'b0;
        hold_wr_r    <= 1'b0;
      end else begin
        hold_addr_r  <= hold_addr_r;
        hold_wdata_r <= hold_wdata_r;
        hold_rd_r    <= hold_rd_r;
        hold_wr_r    <= hold_wr_r;
      end
    end
  end

  // Control strobes are held low while reset is asserted, even mid-BUSY.
  assign cache.c_addr    = c_addr_s;
  assign cache.c_data_in = c_data_in_s;
  assign cache.c_rd      = c_rd_s  & ~rst;
  assign cache.c_wr      = c_wr_s  & ~rst;
  assign pipe.done       = done_s  & ~rst;
  assign pipe.err        = err_s   & ~rst;
  assign pipe.pipe_stall = stall_s & ~rst;
  assign pipe.rd_data    = (rd_done_s & ~rst) ? cache.c_data_out : last_rdata_r;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc_s & ~rst),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc_s & ~rst),
    .count (miss_cnt)
  );

endmodule
